// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results (via skid FIFO) and load responses onto
// the register-file write port and tracks outstanding loads. Macro WB_LOAD_EXT_EN enables load byte/half extraction.
module wb_arbiter #(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int NUM_REGS       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [4:0]          alu_dst,
  input  logic [31:0]         alu_data,
  input  logic                ld_issue,
  input  logic [4:0]          ld_issue_dst,
  input  logic                ld_valid,
  input  logic [4:0]          ld_dst,
  input  logic [31:0]         ld_rdata,
  input  logic [1:0]          ld_addr_lo,
  input  logic [1:0]          ld_size,
  input  logic                ld_signed,
  output logic                rf_w_en,
  output logic [4:0]          rf_w_pos,
  output logic [31:0]         rf_w_data,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int AW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ALU_FIFO_DEPTH);

  logic [4:0]    fifo_dst  [ALU_FIFO_DEPTH];
  logic [31:0]   fifo_data [ALU_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          fifo_nonempty, alu_fire, bypass, push, pop;
  logic          wr_sel;
  logic [4:0]    wr_dst;
  logic [31:0]   wr_data;
  logic [31:0]   ld_wdata;
  logic [NUM_REGS-1:0] busy_next;

  assign alu_ready     = (count < DEPTH_C);
  assign fifo_nonempty = (count != '0);
  assign alu_fire      = alu_valid && alu_ready;
  assign bypass        = alu_fire && !ld_valid && !fifo_nonempty;
  assign push          = alu_fire && !bypass;
  assign pop           = !ld_valid && fifo_nonempty;
  assign wr_sel        = ld_valid || fifo_nonempty || alu_fire;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte  = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half  = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      2'd0:    ld_wdata = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'd1:    ld_wdata = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_wdata = ld_rdata;
    endcase
  end
`else
  // Memory side pre-aligns data; the alignment inputs are intentionally unused.
  logic unused_ld_fmt;
  assign unused_ld_fmt = ^{ld_addr_lo, ld_size, ld_signed};
  assign ld_wdata      = ld_rdata;
`endif

  always_comb begin
    wr_dst  = alu_dst;
    wr_data = alu_data;
    if (ld_valid) begin
      wr_dst  = ld_dst;
      wr_data = ld_wdata;
    end else if (fifo_nonempty) begin
      wr_dst  = fifo_dst[rd_ptr];
      wr_data = fifo_data[rd_ptr];
    end
  end

  // Set after clear so a younger issue to the same register wins.
  always_comb begin
    busy_next = busy_mask;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ld_valid && ld_dst == 5'(r)) busy_next[r] = 1'b0;
      if (ld_issue && ld_issue_dst != 5'd0 && ld_issue_dst == 5'(r)) busy_next[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dst[wr_ptr]  <= alu_dst;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      busy_mask <= '0;
      rf_w_en   <= 1'b0;
      rf_w_pos  <= '0;
      rf_w_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      busy_mask <= busy_next;
      rf_w_en   <= 1'b0;
      // r0 writes consume the slot but never reach the register file.
      if (wr_sel && wr_dst != 5'd0) begin
        rf_w_en   <= 1'b1;
        rf_w_pos  <= wr_dst;
        rf_w_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; one task per scenario.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_dst;
  logic        ld_valid;
  logic [4:0]  ld_dst;
  logic [31:0] ld_rdata;
  logic [1:0]  ld_addr_lo;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        rf_w_en;
  logic [4:0]  rf_w_pos;
  logic [31:0] rf_w_data;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ALU_FIFO_DEPTH(2), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
    .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_rdata(ld_rdata),
    .ld_addr_lo(ld_addr_lo), .ld_size(ld_size), .ld_signed(ld_signed),
    .rf_w_en(rf_w_en), .rf_w_pos(rf_w_pos), .rf_w_data(rf_w_data),
    .busy_mask(busy_mask)
  );

  task automatic idle_inputs();
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    ld_issue = 0; ld_issue_dst = 0;
    ld_valid = 0; ld_dst = 0; ld_rdata = 0;
    ld_addr_lo = 0; ld_size = 2'd2; ld_signed = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", rf_w_en); end
    total++; if (rf_w_pos !== 5'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", rf_w_pos); end
    total++; if (rf_w_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rf_w_data); end
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alu_ready); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream();
    ld_issue = 1; ld_issue_dst = 5'd4;
    step();
    ld_issue = 0;
    ld_valid = 1; ld_dst = 5'd3; ld_rdata = 32'h1;
    alu_valid = 1; alu_dst = 5'd7; alu_data = 32'h77;
    step();
    alu_dst = 5'd8; alu_data = 32'h88;
    step();
    idle_inputs();
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL mid_full_ready got=%b exp=0", alu_ready); end
    total++; if (busy_mask !== 32'h0000_0010) begin bad++; $display("FAIL mid_busy got=%h exp=00000010", busy_mask); end
    #2 rst = 1'b1;
    #1;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL mid_rst_en got=%b exp=0", rf_w_en); end
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL mid_rst_busy got=%h exp=0", busy_mask); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", alu_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL mid_post_write cyc=%0d got=%b exp=0", i, rf_w_en); end
    end
  endtask

  task automatic test_bypass();
    alu_valid = 1; alu_dst = 5'd5; alu_data = 32'h1234_5678;
    step();
    alu_valid = 0;
    total++; if (rf_w_en !== 1'b1) begin bad++; $display("FAIL byp_en got=%b exp=1", rf_w_en); end
    total++; if (rf_w_pos !== 5'd5) begin bad++; $display("FAIL byp_pos got=%0d exp=5", rf_w_pos); end
    total++; if (rf_w_data !== 32'h1234_5678) begin bad++; $display("FAIL byp_data got=%h exp=12345678", rf_w_data); end
    step();
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL byp_next_en got=%b exp=0", rf_w_en); end
    total++; if (rf_w_pos !== 5'd5 || rf_w_data !== 32'h1234_5678)
      begin bad++; $display("FAIL byp_hold got=%0d/%h exp=5/12345678", rf_w_pos, rf_w_data); end
  endtask

  task automatic test_load_priority();
    logic        ldv [6] = '{1, 1, 1, 0, 0, 0};
    logic        av  [6] = '{1, 1, 1, 1, 1, 0};
    logic [4:0]  ad  [6] = '{7, 8, 9, 9, 9, 0};
    logic        rdy [6] = '{1, 1, 0, 0, 1, 1};
    logic [4:0]  epos[6] = '{3, 3, 3, 7, 8, 9};
    logic [31:0] edat[6] = '{32'hA0, 32'hA1, 32'hA2, 32'h700, 32'h800, 32'h900};
    for (int i = 0; i < 6; i++) begin
      ld_valid = ldv[i]; ld_dst = 5'd3; ld_rdata = 32'hA0 + 32'(i); ld_size = 2'd2;
      alu_valid = av[i]; alu_dst = ad[i]; alu_data = {20'd0, ad[i] - 5'd7 + 5'd7, 8'd0};
      alu_data = (ad[i] == 5'd7) ? 32'h700 : (ad[i] == 5'd8) ? 32'h800 : 32'h900;
      #1;
      total++; if (alu_ready !== rdy[i]) begin bad++; $display("FAIL prio_ready cyc=%0d got=%b exp=%b", i, alu_ready, rdy[i]); end
      step();
      total++; if (rf_w_en !== 1'b1 || rf_w_pos !== epos[i] || rf_w_data !== edat[i])
        begin bad++; $display("FAIL prio_write cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_w_en, rf_w_pos, rf_w_data, epos[i], edat[i]); end
    end
    idle_inputs();
    step();
    total++; if (rf_w_en !== 1'b0 || alu_ready !== 1'b1)
      begin bad++; $display("FAIL prio_drain got=%b/%b exp=0/1", rf_w_en, alu_ready); end
  endtask

  task automatic test_scoreboard();
    ld_issue = 1; ld_issue_dst = 5'd10;
    step();
    ld_issue = 0;
    total++; if (busy_mask !== 32'h0000_0400) begin bad++; $display("FAIL sb_set got=%h exp=00000400", busy_mask); end
    step();
    ld_issue = 1; ld_issue_dst = 5'd10;
    ld_valid = 1; ld_dst = 5'd10; ld_rdata = 32'hCAFE_0010; ld_size = 2'd2;
    step();
    ld_issue = 0;
    total++; if (busy_mask !== 32'h0000_0400) begin bad++; $display("FAIL sb_set_wins got=%h exp=00000400", busy_mask); end
    total++; if (rf_w_en !== 1'b1 || rf_w_pos !== 5'd10 || rf_w_data !== 32'hCAFE_0010)
      begin bad++; $display("FAIL sb_write got=%b/%0d/%h exp=1/10/cafe0010", rf_w_en, rf_w_pos, rf_w_data); end
    step();
    ld_valid = 0;
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL sb_clear got=%h exp=0", busy_mask); end
    step();
  endtask

  task automatic test_load_ext();
    logic [1:0]  a  [5] = '{3, 2, 0, 3, 1};
    logic [1:0]  sz [5] = '{0, 1, 0, 1, 3};
    logic        sg [5] = '{1, 0, 0, 1, 1};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_0001, 32'hFFFF_80FF, 32'h80FF_7F01};
`else
    logic [31:0] ex [5] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_dst = 5'd12; ld_rdata = 32'h80FF_7F01;
      ld_addr_lo = a[i]; ld_size = sz[i]; ld_signed = sg[i];
      step();
      total++; if (rf_w_en !== 1'b1 || rf_w_pos !== 5'd12 || rf_w_data !== ex[i])
        begin bad++; $display("FAIL ext case=%0d got=%b/%0d/%h exp=1/12/%h", i, rf_w_en, rf_w_pos, rf_w_data, ex[i]); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_r0();
    alu_valid = 1; alu_dst = 5'd0; alu_data = 32'hDEAD_0000;
    step();
    alu_valid = 0;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL r0_alu got=%b exp=0", rf_w_en); end
    ld_valid = 1; ld_dst = 5'd0; ld_rdata = 32'hDEAD_0001;
    step();
    ld_valid = 0;
    total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL r0_load got=%b exp=0", rf_w_en); end
    ld_issue = 1; ld_issue_dst = 5'd6;
    step();
    ld_issue_dst = 5'd0;
    step();
    ld_issue = 0;
    total++; if (busy_mask !== 32'h0000_0040) begin bad++; $display("FAIL r0_issue got=%h exp=00000040", busy_mask); end
    ld_valid = 1; ld_dst = 5'd6; ld_rdata = 32'h6;
    step();
    ld_valid = 0;
    total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL r0_clear6 got=%h exp=0", busy_mask); end
    step();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_bypass();
    test_load_priority();
    test_scoreboard();
    test_load_ext();
    test_r0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter and load scoreboard. It sits in front of the CPU register file and is the only source of its write port.
- It merges single-cycle ALU results with out-of-order-latency load responses from the AXI data side, and performs load byte/half extraction.
- At most one register write is issued per cycle.
- It publishes a busy mask of registers with outstanding loads so that decode can stall on RAW/WAW hazards.

Parameters:
- ALU_FIFO_DEPTH, 2, ALU result skid-FIFO entries (power of two, 2..8)
- NUM_REGS, 32, architectural registers; width of busy_mask

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  FIFO can accept; transfer when alu_valid&&alu_ready
- alu_dst  in  5  destination register
- alu_data  in  32  result value
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_dst  in  5  its destination register
- ld_valid  in  1  load response present; always accepted
- ld_dst  in  5  response destination
- ld_rdata  in  32  raw aligned word from bus
- ld_addr_lo  in  2  byte address bits [1:0]
- ld_size  in  2  0=byte, 1=half, 2=word
- ld_signed  in  1  sign-extend byte/half
- rf_w_en  out  1  register-file write enable
- rf_w_pos  out  5  write register number
- rf_w_data  out  32  write data
- busy_mask  out  NUM_REGS  bit r set = load to r outstanding

Behaviour:
- Reset (async, rst=1):
  - rf_w_en=0, rf_w_pos=0, rf_w_data=0.
  - busy_mask=0, FIFO empty, alu_ready=1.
  - Any in-flight writes are discarded.
- All rf_* outputs are registered. A request selected at edge N appears on rf_* during cycle N+1 for exactly one cycle. The register file commits on the falling edge of that cycle.
- Arbitration at each edge, in priority order:
  - ld_valid present: the load response is written.
  - Else, FIFO non-empty: the FIFO head is written and popped.
  - Else, alu_valid accepted: the ALU result is written directly (bypass) and not enqueued.
  - Else: rf_w_en=0, and rf_w_pos/rf_w_data hold their previous values.
- ALU acceptance:
  - alu_ready = (fifo_count < ALU_FIFO_DEPTH), computed from the registered count with no same-cycle pop credit.
  - An accepted ALU result that is not bypassed is pushed to the FIFO tail.
  - A simultaneous push and pop leaves the count unchanged.
  - Results write back in FIFO order.
- Destination 0:
  - Any write to r0 (ALU or load) is dropped: rf_w_en stays 0 and the arbitration slot is still consumed.
  - ld_issue with dst 0 does not set busy.
- Scoreboard:
  - ld_issue with dst r≠0 sets busy_mask[r] at the next edge.
  - The selected load response with dst r clears busy_mask[r] at the same edge its write is registered.
  - Set and clear of the same r at the same edge: set wins, because the issuing load is younger.
  - Decode guarantees no ALU result targets a busy register and no second load issues to a busy register. Violations are undefined.
- Load data path:
  - size=0: byte ld_rdata[8*addr_lo+:8].
  - size=1: half ld_rdata[16*addr_lo[1]+:16]; addr_lo[0] is ignored.
  - size=2: full word.
  - size=3: treated as word.
  - Byte and half results are zero- or sign-extended to 32 bits per ld_signed.
- Starvation: back-to-back ld_valid may hold the FIFO indefinitely. alu_ready drops when the FIFO is full, and no ALU data is ever lost.

Optional Feature:
- WB_LOAD_EXT_EN defined: the byte/half extraction and extension above is present.
- WB_LOAD_EXT_EN undefined:
  - ld_addr_lo, ld_size and ld_signed are ignored.
  - rf_w_data = ld_rdata unchanged, for a memory side that pre-aligns data.
  - Ports remain present.

Test Plan:
1. Reset mid-stream: FIFO holding 2 entries and busy_mask=0x0000_0010; assert rst -> rf_w_en=0, busy_mask=0, alu_ready=1 immediately; no write after release.
2. ALU bypass: alu_valid, dst=5, data=0x1234_5678 on an idle cycle -> next cycle rf_w_en=1, rf_w_pos=5, rf_w_data=0x1234_5678; following cycle rf_w_en=0.
3. Load priority and FIFO order: ld_valid for dst=3 for 3 cycles while ALU offers dst 7, 8, 9 ->
   - alu_ready=0 after the 2nd ALU push.
   - Writes occur in order r3,r3,r3,r7,r8,r9.
   - The 3rd ALU transfer completes once alu_ready returns.
4. Scoreboard: ld_issue dst=10 -> busy_mask bit 10 set next cycle. At completion, issue dst=10 and ld_valid dst=10 in the same cycle -> bit 10 stays 1.
5. Load extraction (WB_LOAD_EXT_EN): rdata=0x80FF_7F01 ->
   - addr_lo=3, byte, signed: write 0xFFFF_FF80.
   - addr_lo=2, half, unsigned: write 0x0000_80FF.
   - Without the macro: write 0x80FF_7F01.
6. r0 writes: ALU dst=0 and load dst=0 -> rf_w_en never asserted. ld_issue dst=0 -> busy_mask unchanged.
